// File: rtl/lfm_chirp_ctrl.sv
// lfm_chirp_ctrl: sequences linear-FM chirps onto the DDS phase-increment
// configuration channel. Each chirp is a PINC ramp (start, signed step,
// fixed length); chirps repeat with a programmable idle gap, either a fixed
// number of times or continuously.
module lfm_chirp_ctrl #(
    parameter int PINC_W = 32,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [PINC_W-1:0] cfg_start_pinc,
    input  logic [PINC_W-1:0] cfg_step_pinc,
    input  logic [LEN_W-1:0]  cfg_chirp_len,
    input  logic [LEN_W-1:0]  cfg_gap_len,
    input  logic [CNT_W-1:0]  cfg_num_chirps,
    output logic              pinc_valid,
    input  logic              pinc_ready,
    output logic [PINC_W-1:0] pinc_data,
    output logic              chirp_first,
    output logic              chirp_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  chirp_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHIRP = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Configuration captured when a sequence is accepted
    logic        [PINC_W-1:0] r_start_pinc;
    logic signed [PINC_W-1:0] r_step_pinc;
    logic        [LEN_W-1:0]  r_len;
    logic        [LEN_W-1:0]  r_gap_len;
    logic        [CNT_W-1:0]  r_num;

    // Running datapath state
    logic [PINC_W-1:0] r_pinc;
    logic [LEN_W-1:0]  r_smp;
    logic [LEN_W-1:0]  r_gap_cnt;
    logic [CNT_W-1:0]  r_chirp_cnt;

    logic [PINC_W-1:0] w_pinc_nxt;
    logic [LEN_W-1:0]  w_smp_nxt;
    logic [LEN_W-1:0]  w_gap_cnt_nxt;
    logic [CNT_W-1:0]  w_chirp_cnt_nxt;
    logic              w_load_cfg;

    logic [PINC_W-1:0] w_pinc_step;
    logic [CNT_W-1:0]  w_chirp_inc;
    logic              w_first;
    logic              w_last;

    // Step is two's complement; the sum wraps modulo 2^PINC_W by design
    assign w_pinc_step = PINC_W'($signed(r_pinc) + r_step_pinc);
    assign w_chirp_inc = r_chirp_cnt + CNT_W'(1);
    assign w_first     = (r_smp == '0);
    assign w_last      = (r_smp == (r_len - LEN_W'(1)));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath next values and Moore outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_pinc_nxt      = r_pinc;
        w_smp_nxt       = r_smp;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_chirp_cnt_nxt = r_chirp_cnt;
        w_load_cfg      = 1'b0;
        pinc_valid      = 1'b0;
        chirp_first     = 1'b0;
        chirp_last      = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;

        case (r_state)
            S_CHIRP: begin
                pinc_valid  = 1'b1;
                busy        = 1'b1;
                chirp_first = w_first;
                chirp_last  = w_last;
            end
            S_GAP:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase

        // Abort overrides every transition; a word accepted in this cycle is dropped
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (cfg_chirp_len != '0)) begin
                        w_load_cfg      = 1'b1;
                        w_chirp_cnt_nxt = '0;
                        w_pinc_nxt      = cfg_start_pinc;
                        w_smp_nxt       = '0;
                        w_gap_cnt_nxt   = '0;
                        w_state_nxt     = S_CHIRP;
                    end
                end
                S_CHIRP: begin
                    if (pinc_ready) begin
                        w_pinc_nxt = w_pinc_step;
                        w_smp_nxt  = r_smp + LEN_W'(1);
                        if (w_last) begin
                            w_chirp_cnt_nxt = w_chirp_inc;
                            w_smp_nxt       = '0;
                            if ((r_num != '0) && (w_chirp_inc == r_num)) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                // Next chirp restarts the ramp; with no gap it follows without a bubble
                                w_pinc_nxt = r_start_pinc;
                                if (r_gap_len != '0) begin
                                    w_gap_cnt_nxt = '0;
                                    w_state_nxt   = S_GAP;
                                end
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == (r_gap_len - LEN_W'(1))) begin
                        w_gap_cnt_nxt = '0;
                        w_state_nxt   = S_CHIRP;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + LEN_W'(1);
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath and configuration registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_pinc <= '0;
            r_step_pinc  <= '0;
            r_len        <= '0;
            r_gap_len    <= '0;
            r_num        <= '0;
            r_pinc       <= '0;
            r_smp        <= '0;
            r_gap_cnt    <= '0;
            r_chirp_cnt  <= '0;
        end else begin
            if (w_load_cfg) begin
                r_start_pinc <= cfg_start_pinc;
                r_step_pinc  <= $signed(cfg_step_pinc);
                r_len        <= cfg_chirp_len;
                r_gap_len    <= cfg_gap_len;
                r_num        <= cfg_num_chirps;
            end
            r_pinc      <= w_pinc_nxt;
            r_smp       <= w_smp_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_chirp_cnt <= w_chirp_cnt_nxt;
        end
    end

    assign pinc_data   = r_pinc;
    assign chirp_count = r_chirp_cnt;

endmodule

// File: doc/lfm_chirp_ctrl.md
Name: lfm_chirp_ctrl

Overview:
- Sequencer that drives the phase-increment (PINC) configuration channel of the DDS stream core.
- Generates linear-FM chirps as a per-sample PINC ramp: start PINC, signed step, fixed sample count.
- Repeats chirps with a programmable idle gap for a programmed count, or continuously.
- Sits between the register/control layer and the DDS config input; the DDS consumes one PINC word per output sample.

Parameters:
- PINC_W, 32, width of phase increment / phase accumulator word
- LEN_W, 16, width of chirp length and gap length counters
- CNT_W, 16, width of chirp repetition counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  begin chirp sequence; sampled in IDLE only
- abort  in  1  terminate sequence; any state
- cfg_start_pinc  in  PINC_W  PINC of first sample of each chirp
- cfg_step_pinc  in  PINC_W  signed two's-complement PINC increment per sample
- cfg_chirp_len  in  LEN_W  samples per chirp; 0 is illegal
- cfg_gap_len  in  LEN_W  idle cycles between chirps; 0 = back-to-back
- cfg_num_chirps  in  CNT_W  chirps per sequence; 0 = continuous
- pinc_valid  out  1  PINC word valid toward DDS
- pinc_ready  in  1  DDS accepts PINC word
- pinc_data  out  PINC_W  current PINC word
- chirp_first  out  1  high with first word of each chirp
- chirp_last  out  1  high with last word of each chirp
- busy  out  1  high in CHIRP or GAP
- done  out  1  one-cycle pulse on normal sequence completion
- chirp_count  out  CNT_W  completed chirps in current sequence

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; pinc_valid=0, pinc_data=0, chirp_first=0, chirp_last=0, busy=0, done=0, chirp_count=0; all internal counters 0.
- Handshake: a word transfers on a rising edge with pinc_valid=1 and pinc_ready=1.
  - pinc_data, chirp_first and chirp_last are held stable while pinc_valid=1 and pinc_ready=0.
  - pinc_valid never deasserts without a transfer, except on abort.
- IDLE:
  - start=1 with cfg_chirp_len!=0: latch all cfg_* inputs, clear chirp_count, load pinc_data=cfg_start_pinc and sample counter=0, go to CHIRP.
  - pinc_valid=1 is registered in the cycle after start is sampled.
  - start with cfg_chirp_len=0 is ignored and the block stays IDLE.
  - cfg_* inputs are ignored outside IDLE.
- CHIRP:
  - pinc_valid=1, busy=1.
  - chirp_first=1 while sample counter=0.
  - chirp_last=1 while sample counter=len-1; if len=1, first and last are both 1.
  - On each transfer: pinc_data <= pinc_data + step (modulo 2^PINC_W, wrap silently, no saturation); sample counter +1.
  - On transfer of the last word: chirp_count +1 (wraps modulo 2^CNT_W in continuous mode).
    - If num_chirps!=0 and the new count equals num_chirps: go to DONE.
    - Else if gap_len=0: stay in CHIRP with pinc_data=start_pinc and counter=0, so the next cycle carries the first word of the next chirp (no bubble).
    - Else: go to GAP.
- GAP:
  - pinc_valid=0, busy=1.
  - Stay exactly gap_len cycles, then go to CHIRP with pinc_data=start_pinc and counter=0.
- DONE:
  - One cycle with done=1, pinc_valid=0, busy=0; then IDLE.
  - chirp_count holds its final value until the next accepted start.
- abort=1 (any state, sampled at clock edge):
  - Next state IDLE, pinc_valid=0, busy=0, no done pulse.
  - A word presented in the same cycle that abort is sampled still counts as transferred if pinc_ready=1, but has no effect after abort.
  - abort has priority over start and over all state transitions.
- start=1 while not IDLE: ignored.
- pinc_ready=0 stalls the ramp indefinitely; the gap timer does not run during a stall.
- Latency: start edge to first pinc_valid = 1 cycle. Last-word transfer to first word of next chirp = gap_len+1 cycles when gap_len>0, and 1 cycle (next cycle) when gap_len=0.

Test Plan:
- Basic ramp: start_pinc=0x00100000, step=0x00001000, len=4, gap=0, num=1, ready=1.
  - Required: data 0x00100000, 0x00101000, 0x00102000, 0x00103000 on consecutive cycles; chirp_first on word 0; chirp_last on word 3.
  - Required: done one cycle after the last word; chirp_count=1.
- Negative step and wrap: start_pinc=0x00000010, step=0xFFFFFFF0 (-16), len=3.
  - Required: data 0x00000010, 0x00000000, 0xFFFFFFF0.
- Gap and repetition: len=2, gap=3, num=3.
  - Required: three chirps, each with exactly 3 valid-low cycles between them; no gap after the third chirp; done once; chirp_count=3.
- Backpressure: ready pseudo-random about 50% during len=8.
  - Required: 8 transfers, data stable while stalled, sequence identical to the ready=1 run.
- Abort and illegal start: assert abort mid-chirp with num=0.
  - Required: valid=0 and busy=0 next cycle, no done; a subsequent start restarts from start_pinc.
  - Required: start with len=0 leaves busy=0 and valid=0.
- Async reset mid-chirp: drive reset low between clock edges.
  - Required: all outputs are at their reset values immediately.
